// File: rtl/mem_pkg.sv
// Shared types for the LEGv8 memory stage: access FSM states and the
// EX/MEM and MEM/WB pipeline register layouts.
package mem_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  Branch;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  RegWrite;
    logic                  MemtoReg;
    logic [REG_ADDR_W-1:0] rd;
    logic                  zero;
    logic [DATA_W-1:0]     PCBranch;
    logic [DATA_W-1:0]     aluResult;
    logic [DATA_W-1:0]     writeData;
  } exmem_t;

  typedef struct packed {
    logic                  RegWrite;
    logic                  MemtoReg;
    logic [DATA_W-1:0]     readData;
    logic [DATA_W-1:0]     aluResult;
    logic [REG_ADDR_W-1:0] rd;
  } memwb_t;

  function automatic logic is_memop(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: IDLE/ACCESS/DONE state register, request and
// stall generation, and the load-data capture register.
module mem_access_fsm
  import mem_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memop_E,
  input  logic         memop_M,
  input  logic         MemRead_M,
  input  logic         MemWrite_M,
  input  logic         dm_ready,
  input  logic [N-1:0] dm_rdata,
  output logic         stall_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] rdata_M,
  output mem_state_t   state
);

  mem_state_t state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // IDLE and DONE are the only states in which EX/MEM loads, so they share
  // the same "what is entering" decision.
  always_comb begin
    state_next = state;
    stall_M    = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        state_next = memop_E ? ACCESS : IDLE;
      end
      ACCESS: begin
        stall_M = 1'b1;
        dm_req  = 1'b1;
        dm_we   = MemWrite_M;
        if (dm_ready) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A read+write op is a store, so it never captures read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_M <= '0;
    end else if (state == ACCESS && dm_ready && memop_M && MemRead_M && !MemWrite_M) begin
      rdata_M <= dm_rdata;
    end
  end

endmodule

// File: rtl/memory_mc.sv
// LEGv8 memory stage: EX/MEM register, multi-cycle data-memory handshake,
// CBZ/B branch resolution and the MEM/WB register.
module memory_mc
  import mem_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_E,
  input  logic                  Branch_E,
  input  logic                  MemRead_E,
  input  logic                  MemWrite_E,
  input  logic                  RegWrite_E,
  input  logic                  MemtoReg_E,
  input  logic [REG_ADDR_W-1:0] rd_E,
  input  logic                  zero_E,
  input  logic [N-1:0]          PCBranch_E,
  input  logic [N-1:0]          aluResult_E,
  input  logic [N-1:0]          writeData_E,
  output logic                  stall_M,
  output logic                  PCSrc_M,
  output logic [N-1:0]          PCBranch_M,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [N-1:0]          dm_addr,
  output logic [N-1:0]          dm_wdata,
  input  logic [N-1:0]          dm_rdata,
  input  logic                  dm_ready,
  output logic                  RegWrite_W,
  output logic                  MemtoReg_W,
  output logic [N-1:0]          readData_W,
  output logic [N-1:0]          aluResult_W,
  output logic [REG_ADDR_W-1:0] rd_W
);

  exmem_t     ex_d, ex_q;
  memwb_t     wb_d, wb_q;
  mem_state_t state_M;
  logic [N-1:0] rdata_M;
  logic       memop_E, memop_M, load_M;

  assign memop_E = is_memop(valid_E, MemRead_E, MemWrite_E);
  assign memop_M = is_memop(ex_q.valid, ex_q.MemRead, ex_q.MemWrite);
  assign load_M  = ex_q.MemRead & ~ex_q.MemWrite;

  always_comb begin
    ex_d           = '0;
    ex_d.valid     = valid_E;
    ex_d.Branch    = Branch_E;
    ex_d.MemRead   = MemRead_E;
    ex_d.MemWrite  = MemWrite_E;
    ex_d.RegWrite  = RegWrite_E;
    ex_d.MemtoReg  = MemtoReg_E;
    ex_d.rd        = rd_E;
    ex_d.zero      = zero_E;
    ex_d.PCBranch  = PCBranch_E;
    ex_d.aluResult = aluResult_E;
    ex_d.writeData = writeData_E;
  end

  always_ff @(posedge clk) begin
    if (reset)         ex_q <= '0;
    else if (!stall_M) ex_q <= ex_d;
  end

  mem_access_fsm #(.N(N)) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .memop_E    (memop_E),
    .memop_M    (memop_M),
    .MemRead_M  (ex_q.MemRead),
    .MemWrite_M (ex_q.MemWrite),
    .dm_ready   (dm_ready),
    .dm_rdata   (dm_rdata),
    .stall_M    (stall_M),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .rdata_M    (rdata_M),
    .state      (state_M)
  );

  // While stalled the op is still in M, so a bubble goes to WB instead of a
  // repeated writeback.
  always_comb begin
    wb_d = '0;
    if (!stall_M && ex_q.valid) begin
      wb_d.RegWrite  = ex_q.RegWrite;
      wb_d.MemtoReg  = ex_q.MemtoReg;
      wb_d.readData  = load_M ? rdata_M : '0;
      wb_d.aluResult = ex_q.aluResult;
      wb_d.rd        = ex_q.rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  assign PCSrc_M     = ex_q.valid & ex_q.Branch & ex_q.zero & ~stall_M;
  assign PCBranch_M  = ex_q.PCBranch;
  assign dm_addr     = ex_q.aluResult;
  assign dm_wdata    = ex_q.writeData;
  assign RegWrite_W  = wb_q.RegWrite;
  assign MemtoReg_W  = wb_q.MemtoReg;
  assign readData_W  = wb_q.readData;
  assign aluResult_W = wb_q.aluResult;
  assign rd_W        = wb_q.rd;

endmodule

// File: tb/tb_memory_mc.sv
// Bench for memory_mc: table of single-cycle ops, hand-written memory
// sequences, and a writeback scoreboard fed at issue time.
module tb_memory_mc;
  import mem_pkg::*;

  localparam int W    = 64;
  localparam int WB_W = 5 + 1 + W + W;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
  logic [4:0]   rd_E;
  logic         zero_E;
  logic [W-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic         stall_M, PCSrc_M;
  logic [W-1:0] PCBranch_M;
  logic         dm_req, dm_we;
  logic [W-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         dm_ready;
  logic         RegWrite_W, MemtoReg_W;
  logic [W-1:0] readData_W, aluResult_W;
  logic [4:0]   rd_W;

  int checks   = 0;
  int failures = 0;
  logic [WB_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  memory_mc dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .Branch_E(Branch_E),
    .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E), .RegWrite_E(RegWrite_E),
    .MemtoReg_E(MemtoReg_E), .rd_E(rd_E), .zero_E(zero_E), .PCBranch_E(PCBranch_E),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .stall_M(stall_M),
    .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .readData_W(readData_W),
    .aluResult_W(aluResult_W), .rd_W(rd_W)
  );

  typedef struct {
    logic         valid, branch, regwrite, memtoreg, zero;
    logic [4:0]   rd;
    logic [W-1:0] pcb, alu;
    logic         exp_pcsrc;
    logic         exp_wb;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic v, input logic br, input logic mr, input logic mw,
                          input logic rw, input logic m2r, input logic [4:0] rd,
                          input logic z, input logic [W-1:0] pcb, input logic [W-1:0] alu,
                          input logic [W-1:0] wd);
    valid_E = v; Branch_E = br; MemRead_E = mr; MemWrite_E = mw;
    RegWrite_E = rw; MemtoReg_E = m2r; rd_E = rd; zero_E = z;
    PCBranch_E = pcb; aluResult_E = alu; writeData_E = wd;
  endtask

  task automatic drive_bubble();
    drive_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, '0, '0, '0);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic m2r, input logic [W-1:0] rdata,
                         input logic [W-1:0] alu);
    exp_q.push_back({rd, m2r, rdata, alu});
  endtask

  // scoreboard: every writeback must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && RegWrite_W) begin
      logic [WB_W-1:0] got, exp;
      got = {rd_W, MemtoReg_W, readData_W, aluResult_W};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected: got rd=%0d alu=%h rdata=%h expected no writeback",
                 rd_W, aluResult_W, readData_W);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL wb_data: got %h expected %h", got, exp);
        end
      end
    end
  end

  function automatic vec_t mkvec(logic v, logic br, logic rw, logic z, logic [4:0] rd,
                                 logic [W-1:0] pcb, logic [W-1:0] alu, logic ep, logic ew);
    vec_t t;
    t.valid = v; t.branch = br; t.regwrite = rw; t.memtoreg = 1'b0; t.zero = z;
    t.rd = rd; t.pcb = pcb; t.alu = alu; t.exp_pcsrc = ep; t.exp_wb = ew;
    return t;
  endfunction

  initial begin
    int req_cycles, stall_cycles;
    logic [W-1:0] r;

    vecs[0] = mkvec(1, 0, 1, 0, 5'd3,  64'h0,    64'd5,               0, 1); // ADD
    vecs[1] = mkvec(1, 1, 0, 1, 5'd0,  64'h40,   64'h0,               1, 0); // CBZ taken
    vecs[2] = mkvec(1, 0, 1, 1, 5'd7,  64'h99,   64'hDEAD_BEEF_0000_0001, 0, 1);
    vecs[3] = mkvec(1, 1, 0, 0, 5'd0,  64'h80,   64'h7,               0, 0); // CBZ not taken
    vecs[4] = mkvec(0, 1, 1, 1, 5'd2,  64'h44,   64'h1,               0, 0); // bubble
    vecs[5] = mkvec(1, 1, 0, 1, 5'd0,  64'h1234_5678_9ABC_DEF0, 64'h0, 1, 0);
    vecs[6] = mkvec(1, 0, 1, 0, 5'd31, 64'h0,    64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    vecs[7] = mkvec(0, 0, 1, 0, 5'd9,  64'h0,    64'h55,              0, 0); // bubble

    // reset with noisy inputs
    reset = 1'b1; dm_ready = 1'b1; dm_rdata = '0;
    drive_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 1'b1, 64'h40, 64'h3, 64'h0);
    tick(); tick();
    chk("rst_stall", W'(stall_M), 0);
    chk("rst_dm_req", W'(dm_req), 0);
    chk("rst_pcsrc", W'(PCSrc_M), 0);
    chk("rst_regwrite", W'(RegWrite_W), 0);
    chk("rst_rd_W", W'(rd_W), 0);
    chk("rst_state", W'(dut.u_fsm.state), W'(IDLE));
    drive_bubble(); dm_ready = 1'b0; reset = 1'b0;
    tick();

    // single-cycle ops from the table
    for (int i = 0; i < 8; i++) begin
      drive_op(vecs[i].valid, vecs[i].branch, 1'b0, 1'b0, vecs[i].regwrite, vecs[i].memtoreg,
               vecs[i].rd, vecs[i].zero, vecs[i].pcb, vecs[i].alu, 64'h0);
      if (vecs[i].exp_wb) push_wb(vecs[i].rd, 1'b0, '0, vecs[i].alu);
      tick();
      chk($sformatf("vec%0d_pcsrc", i), W'(PCSrc_M), W'(vecs[i].exp_pcsrc));
      chk($sformatf("vec%0d_stall", i), W'(stall_M), 0);
      if (vecs[i].exp_pcsrc) chk($sformatf("vec%0d_pcbranch", i), PCBranch_M, vecs[i].pcb);
      chk($sformatf("vec%0d_prev_wb", i), W'(RegWrite_W), W'(i > 0 ? vecs[i-1].exp_wb : 1'b0));
    end

    // random ALU ops
    for (int i = 0; i < 6; i++) begin
      r = {$urandom(), $urandom()};
      drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'($urandom_range(0, 31)), 1'b0, '0, r, '0);
      push_wb(rd_E, 1'b0, '0, r);
      tick();
      chk("rand_stall", W'(stall_M), 0);
    end
    drive_bubble();
    tick(); tick();

    // LDUR with two wait cycles
    drive_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, '0, 64'h10, 64'h0);
    push_wb(5'd9, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10);
    dm_ready = 1'b0;
    tick();
    drive_bubble();
    req_cycles = 0; stall_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (dm_req) req_cycles++;
      if (stall_M) stall_cycles++;
      chk("ld_addr", dm_addr, 64'h10);
      chk("ld_we", W'(dm_we), 0);
      chk("ld_bubble_wb", W'(RegWrite_W), 0);
      dm_ready = (i == 2);
      dm_rdata = (i == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h1234;
      tick();
    end
    if (dm_req) req_cycles++;
    if (stall_M) stall_cycles++;
    chk("ld_req_cycles", W'(req_cycles), 3);
    chk("ld_stall_cycles", W'(stall_cycles), 3);
    dm_ready = 1'b0; dm_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    tick();
    chk("ld_wb_regwrite", W'(RegWrite_W), 1);
    chk("ld_wb_rdata", readData_W, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ld_wb_rd", W'(rd_W), 9);
    tick();

    // STUR with immediate ready
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, '0, 64'd8, 64'd1);
    dm_ready = 1'b1;
    tick();
    drive_bubble();
    chk("st_req", W'(dm_req), 1);
    chk("st_we", W'(dm_we), 1);
    chk("st_wdata", dm_wdata, 64'd1);
    chk("st_addr", dm_addr, 64'd8);
    tick();
    chk("st_done_req", W'(dm_req), 0);
    chk("st_done_stall", W'(stall_M), 0);
    tick();
    chk("st_wb_regwrite", W'(RegWrite_W), 0);
    chk("st_wb_rdata", readData_W, 0);
    chk("st_idle_req", W'(dm_req), 0);

    // read+write together behaves as a store
    drive_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, '0, 64'h20, 64'h77);
    tick();
    drive_bubble();
    chk("rw_we", W'(dm_we), 1);
    tick(); tick();
    chk("rw_wb_rdata", readData_W, 0);

    // back-to-back loads
    drive_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, '0, 64'h100, 64'h0);
    push_wb(5'd4, 1'b1, 64'hAAAA_0000_1111_2222, 64'h100);
    dm_rdata = 64'hAAAA_0000_1111_2222;
    tick();
    drive_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, '0, 64'h200, 64'h0);
    push_wb(5'd5, 1'b1, 64'hBBBB_3333_4444_5555, 64'h200);
    tick();
    chk("b2b_done_stall", W'(stall_M), 0);
    dm_rdata = 64'hBBBB_3333_4444_5555;
    tick();
    drive_bubble();
    chk("b2b_second_req", W'(dm_req), 1);
    chk("b2b_second_addr", dm_addr, 64'h200);
    tick(); tick(); tick();
    dm_ready = 1'b0;

    // reset in the middle of an access
    drive_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, '0, 64'h30, 64'h0);
    tick();
    drive_bubble();
    chk("rma_req_before", W'(dm_req), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rma_req", W'(dm_req), 0);
    chk("rma_stall", W'(stall_M), 0);
    chk("rma_state", W'(dut.u_fsm.state), W'(IDLE));
    dm_ready = 1'b1; dm_rdata = 64'hCAFE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rma_late_ready_req", W'(dm_req), 0);
    end
    dm_ready = 1'b0;
    tick(); tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wb_pending: got %0d outstanding writebacks expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_mc.md
Name: memory_mc

Overview:
- Memory stage of the pipelined LEGv8 datapath, directly downstream of the execute stage.
- Contains the EX/MEM pipeline register and consumes the execute outputs: zero_E, PCBranch_E, aluResult_E, writeData_E.
- Drives a multi-cycle data-memory req/ready handshake, stalls upstream while an access is outstanding, resolves CBZ/B branches (PCSrc), and contains the MEM/WB register.

Parameters:
N, 64, datapath width (addresses and data)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
valid_E  in  1  execute stage holds a real instruction (0 = bubble)
Branch_E  in  1  conditional-branch control
MemRead_E  in  1  load (LDUR)
MemWrite_E  in  1  store (STUR)
RegWrite_E  in  1  writeback enable
MemtoReg_E  in  1  writeback source select
rd_E  in  5  destination register
zero_E  in  1  ALU zero flag
PCBranch_E  in  N  branch target
aluResult_E  in  N  ALU result / memory address
writeData_E  in  N  store data
stall_M  out  1  hold execute stage and everything upstream
PCSrc_M  out  1  take branch
PCBranch_M  out  N  registered branch target
dm_req  out  1  data-memory request
dm_we  out  1  1 = write
dm_addr  out  N  = aluResult_M
dm_wdata  out  N  = writeData_M
dm_rdata  in  N  read data, valid with dm_ready
dm_ready  in  1  access complete this cycle
RegWrite_W  out  1  MEM/WB writeback enable
MemtoReg_W  out  1  MEM/WB select
readData_W  out  N  loaded data
aluResult_W  out  N  passed-through ALU result
rd_W  out  5  destination register

Behaviour:
- Reset: EX/MEM and MEM/WB registers zeroed (valid_M=0, all controls 0, data 0), FSM=IDLE. All outputs 0 in the cycle after reset is sampled high, including stall_M, dm_req and PCSrc_M. Reset has priority over every other event.
- EX/MEM register loads all *_E inputs at an edge when stall_M=0; holds when stall_M=1.
- memop_M = valid_M & (MemRead_M | MemWrite_M).
- FSM states IDLE, ACCESS, DONE:
  - Next state is computed at every edge where EX/MEM loads: an entering memop goes to ACCESS, anything else goes to IDLE.
  - IDLE: stall_M=0; dm_req=0.
  - ACCESS: dm_req=1, stall_M=1, dm_we=MemWrite_M. Go to DONE at the edge where dm_ready=1, latching dm_rdata into an internal register for loads. Otherwise stay; dm_req held high and address/data stable.
  - DONE: dm_req=0, stall_M=0. The op advances to MEM/WB at this edge. Next state is ACCESS if a new memop enters, else IDLE.
- Latency:
  - Non-memory op: 1 cycle in M.
  - Memory op: 2+k cycles, where k is the number of ACCESS cycles with dm_ready=0.
  - Back-to-back memops: no idle cycle between the DONE of one and the ACCESS of the next.
- dm_ready outside ACCESS: ignored.
- MemRead_M & MemWrite_M both set: treated as a store; readData_W=0.
- Stores: readData_W=0.
- MEM/WB register:
  - Loads at every edge.
  - While stall_M=1, it loads a bubble (RegWrite_W=0, MemtoReg_W=0, data 0, rd_W=0) so writeback never repeats.
  - Bubble (valid_M=0): RegWrite_W=0.
- PCSrc_M = valid_M & Branch_M & zero_M & ~stall_M. It is combinational from M registers and therefore asserted for exactly one cycle per taken branch.
- PCBranch_M is driven directly from the EX/MEM register.
- Reset mid-ACCESS: dm_req is 0 the cycle after reset is sampled, and the access is abandoned.

Decomposition:
- Shared package (mem_pkg):
  - mem_state_t enum {IDLE, ACCESS, DONE}.
  - exmem_t packed struct: valid, Branch, MemRead, MemWrite, RegWrite, MemtoReg, rd, zero, PCBranch, aluResult, writeData.
  - memwb_t struct.
  - Width constant REG_ADDR_W=5.
- Sub-module mem_access_fsm owns the state register, dm_req/dm_we/stall_M generation and the rdata latch. memory_mc holds the pipeline registers.

Test Plan:
- Reset held 2 cycles with dm_ready=1, Branch_E=1 → stall_M, dm_req, PCSrc_M, RegWrite_W all 0; rd_W=0.
- ADD-type op (RegWrite_E=1, aluResult_E=64'd5, rd_E=3) → one cycle later RegWrite_W=1, aluResult_W=5, rd_W=3; stall_M never 1.
- LDUR (MemRead_E=1, aluResult_E=64'h10, rd_E=9), dm_ready held 0 for 2 cycles then 1 with dm_rdata=64'hFFFFFFFFFFFFFFFF:
  - dm_addr=64'h10.
  - dm_req high 3 cycles, stall_M high 3 cycles.
  - Then readData_W=64'hFFFFFFFFFFFFFFFF, MemtoReg_W=1, rd_W=9.
  - Bubbles (RegWrite_W=0) during stall.
- STUR (MemWrite_E=1, aluResult_E=8, writeData_E=64'd1), dm_ready=1 immediately → dm_we=1, dm_wdata=1 for one ACCESS cycle; 2 cycles in M; RegWrite_W=0.
- CBZ (Branch_E=1, zero_E=1, PCBranch_E=64'h40) → PCSrc_M=1 for exactly 1 cycle, PCBranch_M=64'h40. With zero_E=0 → PCSrc_M stays 0.
- Reset asserted during ACCESS with dm_ready=0 → next cycle dm_req=0, stall_M=0, FSM IDLE. A later dm_ready=1 pulse causes no writeback.
